// File: rtl/rgb_window3x3_gen_if.sv
// ============================================================================
// Module   : rgb_window3x3_gen_if
// Purpose  : Bundle for the RGB 3x3 window generator. It carries the raster
//            pixel input (valid/sof/r/g/b) and the registered window output
//            (27 values plus the out_valid, out_last and frame_done strobes).
// Ports    : none (signal bundle only)
//   master : pixel source / window consumer. It drives in_*.
//   slave  : window generator. It drives a_*..i_*, out_valid, out_last and
//            frame_done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb_window3x3_gen_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_r, in_g, in_b;

  logic [DW-1:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r;
  logic [DW-1:0] a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g;
  logic [DW-1:0] a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b;
  logic          out_valid;
  logic          out_last;
  logic          frame_done;

  modport master (
    output in_valid, in_sof, in_r, in_g, in_b,
    input  a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r,
    input  a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g,
    input  a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b,
    input  out_valid, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_g, in_b,
    output a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r,
    output a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g,
    output a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b,
    output out_valid, out_last, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/rgb_window3x3_gen.sv
// ============================================================================
// Module   : rgb_window3x3_gen
// Purpose  : Converts a raster-order RGB pixel stream into a registered 3x3
//            neighbourhood per colour channel. Windows are emitted only for
//            interior centre pixels.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous reset, active low
//            s_if  - slave side of rgb_window3x3_gen_if
//                    (pixel input and window output)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_window3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  rgb_window3x3_gen_if.slave s_if
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = 3 * DW;   // packed pixel {r, g, b}

  localparam logic [CW-1:0] c_COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_COL_TWO = CW'(2);
  localparam logic [RW-1:0] c_ROW_TWO = RW'(2);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_acc;
  logic          w_win;
  logic          w_eof;
  logic [PW-1:0] w_pix;
  logic [PW-1:0] w_lb0;
  logic [PW-1:0] w_lb1;

  // Line buffers: LB1 holds the previous line, LB0 the line before that.
  logic [PW-1:0] r_lb0 [IMG_W];
  logic [PW-1:0] r_lb1 [IMG_W];

  // Column history per row of the window. Index 0 is the oldest column.
  // The newest column is never stored: it is the live input/LB read taken
  // in the same cycle the window completes.
  logic [PW-1:0] r_top [2];
  logic [PW-1:0] r_mid [2];
  logic [PW-1:0] r_bot [2];

  // Registered window in raster order a..i.
  logic [PW-1:0] r_win [9];
  logic          r_ov;
  logic          r_last;
  logic          r_fd;

  // A start-of-frame pixel is treated as (0,0) whatever the counters hold.
  assign w_acc = s_if.in_valid;
  assign w_col = s_if.in_sof ? '0 : r_col;
  assign w_row = s_if.in_sof ? '0 : r_row;
  assign w_pix = {s_if.in_r, s_if.in_g, s_if.in_b};
  assign w_eof = (w_row == c_ROW_MAX) && (w_col == c_COL_MAX);
  assign w_win = w_acc && (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);

  // Asynchronous read. The write below lands on the clock edge, so the
  // value seen here is always the pre-write contents (read-before-write).
  assign w_lb0 = r_lb0[w_col];
  assign w_lb1 = r_lb1[w_col];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col == c_COL_MAX) begin
        r_col <= '0;
        r_row <= (w_row == c_ROW_MAX) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  // No reset on the line buffers: stale contents are never used, because
  // a window needs row>=2, by which point both lines have been rewritten.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[w_col] <= w_lb1;
      r_lb1[w_col] <= w_pix;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        r_top[k] <= '0;
        r_mid[k] <= '0;
        r_bot[k] <= '0;
      end
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
      r_ov   <= 1'b0;
      r_last <= 1'b0;
      r_fd   <= 1'b0;
    end else begin
      r_ov   <= w_win;
      r_last <= w_win && w_eof;
      r_fd   <= w_acc && w_eof;
      if (w_acc) begin
        r_top[0] <= r_top[1];
        r_top[1] <= w_lb0;
        r_mid[0] <= r_mid[1];
        r_mid[1] <= w_lb1;
        r_bot[0] <= r_bot[1];
        r_bot[1] <= w_pix;
      end
      if (w_win) begin
        r_win[0] <= r_top[0];
        r_win[1] <= r_top[1];
        r_win[2] <= w_lb0;
        r_win[3] <= r_mid[0];
        r_win[4] <= r_mid[1];
        r_win[5] <= w_lb1;
        r_win[6] <= r_bot[0];
        r_win[7] <= r_bot[1];
        r_win[8] <= w_pix;
      end
    end
  end

  assign {s_if.a_r, s_if.a_g, s_if.a_b} = r_win[0];
  assign {s_if.b_r, s_if.b_g, s_if.b_b} = r_win[1];
  assign {s_if.c_r, s_if.c_g, s_if.c_b} = r_win[2];
  assign {s_if.d_r, s_if.d_g, s_if.d_b} = r_win[3];
  assign {s_if.e_r, s_if.e_g, s_if.e_b} = r_win[4];
  assign {s_if.f_r, s_if.f_g, s_if.f_b} = r_win[5];
  assign {s_if.g_r, s_if.g_g, s_if.g_b} = r_win[6];
  assign {s_if.h_r, s_if.h_g, s_if.h_b} = r_win[7];
  assign {s_if.i_r, s_if.i_g, s_if.i_b} = r_win[8];
  assign s_if.out_valid  = r_ov;
  assign s_if.out_last   = r_last;
  assign s_if.frame_done = r_fd;

endmodule

`default_nettype wire
